config_chain_segment: RTL and testbench
=======================================

// Module: config_chain_segment
// PURPOSE
//  Serial configuration segment feeding the select input of one routing multiplexer.
//  Shifts bitstream bits in from the previous segment and passes them on to the next.
//  Holds a double-buffered shadow copy so the mux select never glitches while shifting.
//  The mux sees only committed data.
//  Sits between the tile's configuration chain and the mux config_in port.
// PARAMETERS
//  WIDTH   5   config bits held; a 26-input mux needs 5
//  CNT_W   $clog2(WIDTH+1)   bit-counter width, derived, not overridable
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high
//  config_enable  in   1      shift strobe: one bit per cycle while high
//  config_in      in   1      serial data from the upstream segment
//  config_out     out  1      serial data to the downstream segment = sreg[WIDTH-1]
//  commit         in   1      one-cycle pulse: copy the shift register into config_data
//  config_data    out  WIDTH  committed configuration, driven to the mux config_in
//  loaded         out  1      at least WIDTH bits shifted since the last reset/commit
//  spill          out  1      more than WIDTH bits shifted since the last reset/commit
// BEHAVIOUR
//  Reset (async assert, sync-released by the system):
//   - sreg, config_data and count are 0; state is EMPTY.
//   - config_out, loaded and spill are 0.
//  Shift (config_enable=1): sreg <= {sreg[WIDTH-2:0], config_in}.
//   - Registered, so config_out shows the bit shifted in WIDTH cycles earlier.
//   - The first bit of a WIDTH-bit burst lands in sreg[WIDTH-1] (MSB-first stream).
//  count saturates at WIDTH and never wraps.
//  State machine (2-bit state encoding):
//   - EMPTY   -> PARTIAL on a shift when WIDTH>1; goes straight to LOADED when WIDTH==1.
//   - PARTIAL -> LOADED on the shift that makes count==WIDTH.
//   - LOADED  -> SPILL on any further shift.
//   - SPILL   -> stays SPILL on further shifts.
//   - Any state -> EMPTY on commit; commit has priority over the shift's state update.
//  Flags:
//   - loaded = (state==LOADED || state==SPILL).
//   - spill = (state==SPILL). Spill is normal for upstream segments of a chain, not an error.
//  Commit:
//   - config_data <= sreg at the edge where commit=1, using the pre-shift sreg value.
//   - Commit is always honoured, even in EMPTY or PARTIAL (partial reconfiguration allowed).
//   - Commit clears count and the flags; sreg is retained.
//  Commit and shift in the same cycle:
//   - config_data gets the old sreg; sreg still shifts.
//   - State goes to EMPTY, count=1, and the next state is then computed from count=1.
//   - Net result: state=PARTIAL (LOADED if WIDTH==1).
//  config_data changes only on commit or reset; it is stable for any config_enable activity.
//  Reset mid-shift: everything clears immediately, without waiting for a clock edge.
//   - Partial bits are lost; the chain restarts.
//  Latency:
//   - config_in to config_out: WIDTH cycles.
//   - commit to config_data: 1 cycle.
//   - Flags: valid in the cycle after the causing edge.
// STRUCTURE
//  Shared package kfpga_cfg_pkg:
//   - state typedef cfg_state_t {EMPTY, PARTIAL, LOADED, SPILL}.
//   - Function clog2_p1(w) for counter sizing.
//  Sub-module cfg_shift_reg (WIDTH): serial shift plus serial out.
//  Counter, FSM and shadow register stay in the top module.
//  Chaining: the upper tile-level block wires config_out to the next segment's config_in.
//  commit is broadcast to all segments.
// TESTING (WIDTH=5 unless noted)
//  1. Reset, then shift 1,0,1,1,0 and pulse commit:
//     - config_data=5'b10110.
//     - loaded=1 before commit; loaded=0 and spill=0 after.
//  2. Shift 7 bits 1,1,0,0,1,0,1:
//     - sreg=5'b00101 and spill=1.
//     - config_out emitted 1 then 1 on the 6th and 7th shifts.
//     - config_data stays at its old value until commit.
//  3. Preload sreg=5'b11111, commit, then shift 0 with commit in the same cycle:
//     - config_data=5'b11111 (pre-shift value), sreg=5'b11110, state=PARTIAL.
//  4. Shift 3 bits, assert reset asynchronously mid-cycle:
//     - All outputs read 0 before the next clock edge.
//     - After release, 5 more shifts give loaded=1.
//  5. Commit from EMPTY right after reset:
//     - config_data=0 and loaded=0.
//  6. WIDTH=1 instance: one shift of 1 gives loaded=1; a second shift gives spill=1 and config_out=1.

Source files
------------

// File: rtl/kfpga_cfg_pkg.sv
// rtl/kfpga_cfg_pkg.sv - shared types and sizing helper for configuration chain segments
package kfpga_cfg_pkg;

    // Fill state of a segment since the last reset or commit.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        LOADED  = 2'd2,
        SPILL   = 2'd3
    } cfg_state_t;

    // Bits needed to count from 0 up to and including w.
    function automatic int clog2_p1(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < (w + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - serial-in serial-out configuration shift register
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, clears the register
//   shift_en   shift one bit per cycle while high
//   shift_in   serial data from the upstream segment
//   sreg       parallel view of the register; the first bit of a burst ends up in the MSB
//   shift_out  serial data to the downstream segment (sreg MSB)
module cfg_shift_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [WIDTH-1:0] sreg,
    output logic             shift_out
);

    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sreg <= '0;
                end else if (shift_en) begin
                    sreg <= shift_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sreg <= '0;
                end else if (shift_en) begin
                    sreg <= {sreg[WIDTH-2:0], shift_in};
                end
            end
        end
    endgenerate

    assign shift_out = sreg[WIDTH-1];

endmodule

// File: rtl/config_chain_segment.sv
// rtl/config_chain_segment.sv - double-buffered serial configuration segment for one routing mux
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-high reset
//   config_enable  shift strobe, one bit per cycle while high
//   config_in      serial data from the upstream segment
//   config_out     serial data to the downstream segment
//   commit         one-cycle pulse copying the shift register into config_data
//   config_data    committed configuration driven to the mux select
//   loaded         at least WIDTH bits shifted since the last reset/commit
//   spill          more than WIDTH bits shifted since the last reset/commit
module config_chain_segment
    import kfpga_cfg_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             config_enable,
    input  logic             config_in,
    output logic             config_out,
    input  logic             commit,
    output logic [WIDTH-1:0] config_data,
    output logic             loaded,
    output logic             spill
);

    localparam int CNT_W = clog2_p1(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_next;
    cfg_state_t       state;
    cfg_state_t       base_state;
    cfg_state_t       state_next;

    cfg_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (config_enable),
        .shift_in  (config_in),
        .sreg      (sreg),
        .shift_out (config_out)
    );

    // A commit restarts the fill tracking first; a shift in the same cycle
    // then counts as the first bit of the next burst.
    always_comb begin
        base_cnt   = commit ? '0 : count;
        base_state = commit ? EMPTY : state;
        cnt_next   = base_cnt;
        state_next = base_state;
        if (config_enable) begin
            cnt_next = (base_cnt == CNT_FULL) ? CNT_FULL : base_cnt + CNT_ONE;
            case (base_state)
                EMPTY:   state_next = (WIDTH == 1) ? LOADED : PARTIAL;
                PARTIAL: state_next = (cnt_next == CNT_FULL) ? LOADED : PARTIAL;
                LOADED:  state_next = SPILL;
                SPILL:   state_next = SPILL;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Shadow register samples the pre-shift sreg, so the mux only ever sees
    // a complete committed word regardless of shifting activity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            count       <= '0;
            loaded      <= 1'b0;
            spill       <= 1'b0;
            config_data <= '0;
        end else begin
            state  <= state_next;
            count  <= cnt_next;
            loaded <= (state_next == LOADED) || (state_next == SPILL);
            spill  <= (state_next == SPILL);
            if (commit) begin
                config_data <= sreg;
            end
        end
    end

endmodule

// File: tb/tb_config_chain_segment.sv
// tb/tb_config_chain_segment.sv - directed self-checking bench for config_chain_segment
module tb_config_chain_segment;

    logic       clock;
    logic       reset;
    logic       config_enable;
    logic       config_in;
    logic       config_out;
    logic       commit;
    logic [4:0] config_data;
    logic       loaded;
    logic       spill;

    logic       config_enable_1;
    logic       config_in_1;
    logic       config_out_1;
    logic       commit_1;
    logic [0:0] config_data_1;
    logic       loaded_1;
    logic       spill_1;

    int n_tests;
    int n_fail;

    config_chain_segment #(.WIDTH(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .config_enable (config_enable),
        .config_in     (config_in),
        .config_out    (config_out),
        .commit        (commit),
        .config_data   (config_data),
        .loaded        (loaded),
        .spill         (spill)
    );

    config_chain_segment #(.WIDTH(1)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .config_enable (config_enable_1),
        .config_in     (config_in_1),
        .config_out    (config_out_1),
        .commit        (commit_1),
        .config_data   (config_data_1),
        .loaded        (loaded_1),
        .spill         (spill_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1 ns later.
    task automatic step(input logic en, input logic din, input logic cm);
        @(negedge clock);
        config_enable = en;
        config_in     = din;
        commit        = cm;
        @(posedge clock);
        #1;
        config_enable = 1'b0;
        config_in     = 1'b0;
        commit        = 1'b0;
    endtask

    task automatic step1(input logic en, input logic din, input logic cm);
        @(negedge clock);
        config_enable_1 = en;
        config_in_1     = din;
        commit_1        = cm;
        @(posedge clock);
        #1;
        config_enable_1 = 1'b0;
        config_in_1     = 1'b0;
        commit_1        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [4:0] t1_bits;
    logic [6:0] t2_bits;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        config_enable = 1'b0; config_in = 1'b0; commit = 1'b0;
        config_enable_1 = 1'b0; config_in_1 = 1'b0; commit_1 = 1'b0;
        #12;
        chk("rst_data",   32'(config_data), 32'h0);
        chk("rst_out",    32'(config_out),  32'h0);
        chk("rst_loaded", 32'(loaded),      32'h0);
        chk("rst_spill",  32'(spill),       32'h0);
        @(negedge clock);
        reset = 1'b0;

        // 1: MSB-first burst 1,0,1,1,0 then commit
        t1_bits = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, t1_bits[i], 1'b0);
            if (i == 1) chk("t1_loaded_after4", 32'(loaded), 32'h0);
        end
        chk("t1_loaded_pre", 32'(loaded), 32'h1);
        chk("t1_spill_pre",  32'(spill),  32'h0);
        chk("t1_data_hold",  32'(config_data), 32'h0);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_data",        32'(config_data), 32'h16);
        chk("t1_loaded_post", 32'(loaded), 32'h0);
        chk("t1_spill_post",  32'(spill),  32'h0);

        // 2: over-shift 1,1,0,0,1,0,1
        t2_bits = 7'b1100101;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, t2_bits[i], 1'b0);
            chk("t2_data_stable", 32'(config_data), 32'h16);
            if (i == 2) chk("t2_out5", 32'(config_out), 32'h1);
            if (i == 1) begin
                chk("t2_out6",   32'(config_out), 32'h1);
                chk("t2_spill6", 32'(spill), 32'h1);
            end
        end
        chk("t2_out7",  32'(config_out), 32'h0);
        chk("t2_spill", 32'(spill), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        chk("t2_sreg", 32'(config_data), 32'h05);

        // 3: preload 11111, commit, then shift 0 with commit in the same cycle
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_data_ones", 32'(config_data), 32'h1f);
        step(1'b1, 1'b0, 1'b1);
        chk("t3_data_preshift", 32'(config_data), 32'h1f);
        chk("t3_loaded", 32'(loaded), 32'h0);
        chk("t3_spill",  32'(spill),  32'h0);
        chk("t3_out0",   32'(config_out), 32'h1);
        // sreg=11110 drains out as 1,1,1,0; count=1 means loaded exactly on the 4th extra shift
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t3_out",    32'(config_out), (i < 3) ? 32'h1 : 32'h0);
            chk("t3_loaded_n", 32'(loaded),   (i < 3) ? 32'h0 : 32'h1);
        end

        // 4: three shifts, then asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        chk("t4_spill_pre", 32'(spill), 32'h1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_data",   32'(config_data), 32'h0);
        chk("t4_async_out",    32'(config_out),  32'h0);
        chk("t4_async_loaded", 32'(loaded),      32'h0);
        chk("t4_async_spill",  32'(spill),       32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("t4_loaded_n", 32'(loaded), (i < 4) ? 32'h0 : 32'h1);
        end

        // 5: commit straight after reset
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        chk("t5_data",   32'(config_data), 32'h0);
        chk("t5_loaded", 32'(loaded), 32'h0);

        // 6: WIDTH=1 instance
        step1(1'b1, 1'b1, 1'b0);
        chk("t6_loaded1", 32'(loaded_1), 32'h1);
        chk("t6_spill1",  32'(spill_1),  32'h0);
        step1(1'b1, 1'b1, 1'b0);
        chk("t6_spill2",  32'(spill_1),  32'h1);
        chk("t6_out2",    32'(config_out_1), 32'h1);
        chk("t6_data_hold", 32'(config_data_1), 32'h0);
        step1(1'b0, 1'b0, 1'b1);
        chk("t6_data",    32'(config_data_1), 32'h1);
        chk("t6_loaded_post", 32'(loaded_1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
